axi4_mem_slave: RTL and testbench

AXI4 memory slave: the block whose bus axi4_assertion monitors.
- Accepts INCR write and read bursts on the axi4_if slave side.
- Stores data in an internal word-addressed RAM of MEMORY_DEPTH words.
- Write and read channels run independent FSMs and may be active simultaneously.

---
 rtl/axi4_pkg.sv | 27 ++
 rtl/axi4_if.sv | 62 ++++++
 rtl/axi4_mem_ram.sv | 30 +++
 rtl/axi4_mem_slave.sv | 206 ++++++++++++++++++++
 tb/tb_axi4_mem_slave.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared types for the AXI4 memory slave: response codes, channel FSM states
// and the bytes-per-beat helper.
package axi4_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } r_state_t;

  // Largest legal AxSIZE for a bus of the given width.
  function automatic logic [2:0] beat_size_log2(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 write/read channel bundle (no IDs, INCR bursts only) with master and
// slave views.
interface axi4_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axi4_mem_ram.sv
// Single-clock word RAM: one byte-enabled write port and one registered read
// port. A same-cycle read of the word being written returns the old contents.
module axi4_mem_ram #(
  parameter int  DATA_WIDTH   = 32,
  parameter int  MEMORY_DEPTH = 1024,
  localparam int ADDR_BITS    = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1,
  localparam int STRB_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  // NOTE: the array and read register have no reset so this maps onto block
  // RAM; a reset loop over every word would force it into flops.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_WIDTH; i++) begin
      if (we && wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 INCR-burst memory slave. Independent write (AW/W/B) and read (AR/R)
// FSMs share one RAM; out-of-range beats and oversized bursts answer SLVERR.
module axi4_mem_slave
  import axi4_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input logic   ACLK,
  input logic   ARESETn,
  axi4_if.slave bus
);

  localparam int              SHIFT    = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0]      MAX_SIZE = beat_size_log2(DATA_WIDTH);
  localparam int              RAM_AW   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(MEMORY_DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr >> SHIFT} < DEPTH;
  endfunction

  function automatic logic [RAM_AW-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    return RAM_AW'(addr >> SHIFT);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size);
    return addr + (ADDR_WIDTH'(1) << size);
  endfunction

  // Write channel state
  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [2:0]            w_size;
  logic [7:0]            w_cnt;
  logic                  w_illegal;
  logic                  w_err;
  logic                  awready;
  logic                  wready;
  logic                  bvalid;
  resp_t                 bresp;

  logic w_fire;
  logic w_last_cnt;
  logic w_beat_err;
  logic ram_we;

  assign w_fire     = (w_state == W_DATA) && wready && bus.WVALID;
  assign w_last_cnt = (w_cnt == 8'd0);
  assign w_beat_err = w_err || w_illegal || !in_range(w_addr) || (bus.WLAST != w_last_cnt);
  assign ram_we     = w_fire && !w_illegal && in_range(w_addr);

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state   <= W_IDLE;
      w_addr    <= '0;
      w_size    <= '0;
      w_cnt     <= '0;
      w_illegal <= 1'b0;
      w_err     <= 1'b0;
      awready   <= 1'b1;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (bus.AWVALID && awready) begin
            w_addr    <= bus.AWADDR;
            w_size    <= bus.AWSIZE;
            w_cnt     <= bus.AWLEN;
            w_illegal <= bus.AWSIZE > MAX_SIZE;
            w_err     <= bus.AWSIZE > MAX_SIZE;
            awready   <= 1'b0;
            wready    <= 1'b1;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_err <= w_beat_err;
            // An early WLAST or a missing one both close the burst here.
            if (w_last_cnt || bus.WLAST) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= w_beat_err ? SLVERR : OKAY;
              w_state <= W_RESP;
            end else begin
              w_cnt  <= w_cnt - 8'd1;
              w_addr <= next_addr(w_addr, w_size);
            end
          end
        end
        W_RESP: begin
          if (bus.BREADY) begin
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Read channel state
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_size;
  logic [7:0]            r_cnt;
  logic                  r_illegal;
  logic                  r_ok;
  logic                  arready;
  logic                  rvalid;
  logic                  rlast;
  resp_t                 rresp;
  logic                  r_beat_bad;

  assign r_beat_bad = r_illegal || !in_range(r_addr);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= R_IDLE;
      r_addr    <= '0;
      r_size    <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_ok      <= 1'b0;
      arready   <= 1'b1;
      rvalid    <= 1'b0;
      rlast     <= 1'b0;
      rresp     <= OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (bus.ARVALID && arready) begin
            r_addr    <= bus.ARADDR;
            r_size    <= bus.ARSIZE;
            r_cnt     <= bus.ARLEN;
            r_illegal <= bus.ARSIZE > MAX_SIZE;
            arready   <= 1'b0;
            r_state   <= R_FETCH;
          end
        end
        R_FETCH: begin
          rvalid  <= 1'b1;
          rlast   <= (r_cnt == 8'd0);
          rresp   <= r_beat_bad ? SLVERR : OKAY;
          r_ok    <= !r_beat_bad;
          r_state <= R_DATA;
        end
        R_DATA: begin
          if (bus.RREADY) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            rresp  <= OKAY;
            r_ok   <= 1'b0;
            if (r_cnt == 8'd0) begin
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_cnt   <= r_cnt - 8'd1;
              r_addr  <= next_addr(r_addr, r_size);
              r_state <= R_FETCH;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] ram_rdata;

  // The RAM read register only changes in R_FETCH, so RDATA stays stable
  // for as long as the beat waits on RREADY.
  axi4_mem_ram #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_ram (
    .clk  (ACLK),
    .we   (ram_we),
    .waddr(word_index(w_addr)),
    .wstrb(bus.WSTRB),
    .wdata(bus.WDATA),
    .re   (r_state == R_FETCH),
    .raddr(word_index(r_addr)),
    .rdata(ram_rdata)
  );

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BRESP   = bresp;
  assign bus.ARREADY = arready;
  assign bus.RVALID  = rvalid;
  assign bus.RLAST   = rlast;
  assign bus.RRESP   = rresp;
  assign bus.RDATA   = r_ok ? ram_rdata : '0;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: single and burst transfers, strobes,
// range and size errors, early WLAST, response hold and mid-burst reset.
module tb_axi4_mem_slave;
  import axi4_pkg::*;

  localparam int BUDGET = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests  = 0;
  int   failed = 0;

  axi4_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  axi4_mem_slave #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (16),
    .MEMORY_DEPTH(1024)
  ) dut (
    .ACLK   (clk),
    .ARESETn(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    failed++;
    $error("FAIL %s: no handshake within %0d cycles", tag, BUDGET);
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [15:0] addr, input logic [7:0] len);
    int n = 0;
    bus.AWADDR  = addr;
    bus.AWLEN   = len;
    bus.AWSIZE  = 3'd2;
    bus.AWVALID = 1'b1;
    while (!bus.AWREADY && n < BUDGET) begin step(); n++; end
    if (!bus.AWREADY) timeout("aw_wait");
    step();
    bus.AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.WDATA  = data;
    bus.WSTRB  = strb;
    bus.WLAST  = last;
    bus.WVALID = 1'b1;
    while (!bus.WREADY && n < BUDGET) begin step(); n++; end
    if (!bus.WREADY) timeout("w_wait");
    step();
    bus.WVALID = 1'b0;
    bus.WLAST  = 1'b0;
  endtask

  task automatic recv_b(output logic [1:0] resp);
    int n = 0;
    bus.BREADY = 1'b1;
    while (!bus.BVALID && n < BUDGET) begin step(); n++; end
    if (!bus.BVALID) timeout("b_wait");
    resp = bus.BRESP;
    step();
    bus.BREADY = 1'b0;
  endtask

  task automatic send_ar(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size);
    int n = 0;
    bus.ARADDR  = addr;
    bus.ARLEN   = len;
    bus.ARSIZE  = size;
    bus.ARVALID = 1'b1;
    while (!bus.ARREADY && n < BUDGET) begin step(); n++; end
    if (!bus.ARREADY) timeout("ar_wait");
    step();
    bus.ARVALID = 1'b0;
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!bus.RVALID && n < BUDGET) begin step(); n++; end
    if (!bus.RVALID) timeout("r_wait");
  endtask

  task automatic recv_r(output logic [31:0] data, output logic [1:0] resp, output logic last);
    wait_rvalid();
    data = bus.RDATA;
    resp = bus.RRESP;
    last = bus.RLAST;
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
  endtask

  task automatic write_single(input string tag, input logic [15:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] resp;
    send_aw(addr, 8'd0);
    send_w(data, strb, 1'b1);
    recv_b(resp);
    check(tag, resp, exp_resp);
  endtask

  task automatic read_single(input string tag, input logic [15:0] addr, input logic [2:0] size,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
    send_ar(addr, 8'd0, size);
    recv_r(d, resp, last);
    check({tag, "_data"}, d, exp_data);
    check({tag, "_resp"}, resp, exp_resp);
    check({tag, "_last"}, last, 1'b1);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
    logic [31:0] burst_data [4];
    burst_data = '{32'd1, 32'd2, 32'd3, 32'd4};

    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = 3'd2; bus.AWVALID = 1'b0;
    bus.WDATA  = '0; bus.WSTRB = '0; bus.WLAST  = 1'b0; bus.WVALID  = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = 3'd2; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;

    #23 rst_n = 1'b1;
    step();

    // Reset state
    check("rst_awready", bus.AWREADY, 1'b1);
    check("rst_arready", bus.ARREADY, 1'b1);
    check("rst_wready",  bus.WREADY,  1'b0);
    check("rst_bvalid",  bus.BVALID,  1'b0);
    check("rst_rvalid",  bus.RVALID,  1'b0);
    check("rst_rlast",   bus.RLAST,   1'b0);
    check("rst_bresp",   bus.BRESP,   OKAY);
    check("rst_rresp",   bus.RRESP,   OKAY);
    check("rst_rdata",   bus.RDATA,   32'h0);

    // Single write, then single read with its first-beat latency
    write_single("t1_bresp", 16'h0010, 32'hDEADBEEF, 4'hF, OKAY);
    bus.ARADDR  = 16'h0010;
    bus.ARLEN   = 8'd0;
    bus.ARSIZE  = 3'd2;
    bus.ARVALID = 1'b1;
    check("t1_arready", bus.ARREADY, 1'b1);
    step();
    bus.ARVALID = 1'b0;
    check("t1_rvalid_c1", bus.RVALID, 1'b0);
    step();
    check("t1_rvalid_c2", bus.RVALID, 1'b1);
    check("t1_rdata", bus.RDATA, 32'hDEADBEEF);
    check("t1_rlast", bus.RLAST, 1'b1);
    check("t1_rresp", bus.RRESP, OKAY);
    bus.RREADY = 1'b1;
    step();
    bus.RREADY = 1'b0;
    check("t1_rvalid_done", bus.RVALID, 1'b0);

    // 4-beat burst write and read with RREADY toggling
    send_aw(16'h0100, 8'd3);
    for (int i = 0; i < 4; i++) send_w(burst_data[i], 4'hF, i == 3);
    recv_b(resp);
    check("t2_bresp", resp, OKAY);
    send_ar(16'h0100, 8'd3, 3'd2);
    for (int i = 0; i < 4; i++) begin
      wait_rvalid();
      check($sformatf("t2_rdata_%0d", i), bus.RDATA, burst_data[i]);
      check($sformatf("t2_rlast_%0d", i), bus.RLAST, i == 3);
      check($sformatf("t2_rresp_%0d", i), bus.RRESP, OKAY);
      step();
      check($sformatf("t2_hold_valid_%0d", i), bus.RVALID, 1'b1);
      check($sformatf("t2_hold_data_%0d", i), bus.RDATA, burst_data[i]);
      bus.RREADY = 1'b1;
      step();
      bus.RREADY = 1'b0;
    end
    check("t2_arready_after", bus.ARREADY, 1'b1);

    // Partial strobe merge
    write_single("t3_bresp_full", 16'h0020, 32'hAABBCCDD, 4'hF, OKAY);
    write_single("t3_bresp_part", 16'h0020, 32'h11223344, 4'h3, OKAY);
    read_single("t3_read", 16'h0020, 3'd2, 32'hAABB3344, OKAY);

    // Out of range: word 1024 must not alias onto word 0
    write_single("t4_bresp_w0", 16'h0000, 32'h12345678, 4'hF, OKAY);
    write_single("t4_bresp_oor", 16'h1000, 32'hFFFFFFFF, 4'hF, SLVERR);
    read_single("t4_read_w0", 16'h0000, 3'd2, 32'h12345678, OKAY);
    read_single("t4_read_oor", 16'h1000, 3'd2, 32'h0, SLVERR);

    // Oversized beat on a 32-bit bus
    read_single("t4_read_size", 16'h0010, 3'd3, 32'h0, SLVERR);

    // Early WLAST with the response held off by BREADY
    send_aw(16'h0200, 8'd3);
    send_w(32'hA1, 4'hF, 1'b0);
    send_w(32'hA2, 4'hF, 1'b1);
    check("t5_wready_closed", bus.WREADY, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t5_bvalid_hold_%0d", k), bus.BVALID, 1'b1);
      check($sformatf("t5_bresp_hold_%0d", k), bus.BRESP, SLVERR);
      step();
    end
    recv_b(resp);
    check("t5_bresp", resp, SLVERR);
    check("t5_bvalid_done", bus.BVALID, 1'b0);
    check("t5_awready_after", bus.AWREADY, 1'b1);

    // Reset during beat 2 of a 4-beat read
    send_ar(16'h0100, 8'd3, 3'd2);
    recv_r(d, resp, last);
    check("t6_beat1", d, 32'd1);
    wait_rvalid();
    check("t6_beat2", bus.RDATA, 32'd2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rvalid",  bus.RVALID,  1'b0);
    check("t6_rst_arready", bus.ARREADY, 1'b1);
    check("t6_rst_rlast",   bus.RLAST,   1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    read_single("t6_after", 16'h0010, 3'd2, 32'hDEADBEEF, OKAY);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
